// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch queue: PC step, FSM state codes, fetch entry.
package if_pkg;

    localparam int unsigned PC_INC  = 4;
    localparam int unsigned IF_XLEN = 32;
    localparam int unsigned IF_ILEN = 32;

    typedef logic [0:0] if_state_t;
    localparam if_state_t S_RUN   = 1'b0;
    localparam if_state_t S_FLUSH = 1'b1;

    // Default-width entry; the top builds its own from XLEN/ILEN.
    typedef struct packed {
        logic [IF_XLEN-1:0] pc;
        logic [IF_ILEN-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Circular buffer for fetched instructions with synchronous clear and occupancy count.
module fetch_fifo
    import if_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic                   i_clear,
    input  logic [WIDTH-1:0]       i_data,
    output logic [WIDTH-1:0]       o_data,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    head_q;
    logic [PW-1:0]    tail_q;
    logic [PW:0]      count_q;
    logic             do_pop;

    assign do_pop  = i_pop && !o_empty;
    assign o_full  = (count_q == (PW+1)'(DEPTH));
    assign o_empty = (count_q == '0);
    assign o_count = count_q;
    assign o_data  = mem_q[head_q];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (i_push) begin
                tail_q <= tail_q + PW'(1);
            end
            if (do_pop) begin
                head_q <= head_q + PW'(1);
            end
            case ({i_push, do_pop})
                2'b10:   count_q <= count_q + (PW+1)'(1);
                2'b01:   count_q <= count_q - (PW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_push && !i_clear && !i_rst) begin
            mem_q[tail_q] <= i_data;
        end
    end

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage: PC, credit-limited imem requests, fetch queue, redirect flush.
// Optional perf counters when IF_FETCH_QUEUE_PERF_EN is defined.
module if_fetch_queue
    import if_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     ILEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = 32'h00000000
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_redirect,
    input  logic [XLEN-1:0] i_redirect_pc,
    output logic            o_imem_req,
    output logic [XLEN-1:0] o_imem_addr,
    input  logic [ILEN-1:0] i_imem_rdata,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [ILEN-1:0] o_inst,
    output logic [XLEN-1:0] o_pc,
`ifdef IF_FETCH_QUEUE_PERF_EN
    output logic [31:0]     o_fetch_cnt,
    output logic [31:0]     o_flush_cnt,
`endif
    output logic [XLEN-1:0] o_pc_plus4
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] inst;
    } entry_t;

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] req_pc_q;
    logic            inflight_q;
    if_state_t       state_q;
    if_state_t       state_d;

    logic            kill;
    logic            push;
    logic            pop;
    logic            full;
    logic            empty;
    logic [CW-1:0]   count;
    logic [CW:0]     credit_use;
    entry_t          wr_entry;
    entry_t          head_entry;

    // Outstanding request counts against queue space so a response always has a slot.
    assign credit_use  = {1'b0, count} + {{CW{1'b0}}, inflight_q};
    assign o_imem_req  = !i_rst && !i_redirect && (credit_use < (CW+1)'(DEPTH));
    assign o_imem_addr = pc_q;

    assign kill = (state_q == S_FLUSH);
    assign push = inflight_q && !kill && !i_redirect;
    assign pop  = o_valid && i_ready;

    assign wr_entry.pc   = req_pc_q;
    assign wr_entry.inst = i_imem_rdata;

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (XLEN + ILEN)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (push),
        .i_pop   (pop),
        .i_clear (i_redirect),
        .i_data  (wr_entry),
        .o_data  (head_entry),
        .o_full  (full),
        .o_empty (empty),
        .o_count (count)
    );

    assign o_valid    = !empty;
    assign o_inst     = head_entry.inst;
    assign o_pc       = head_entry.pc;
    assign o_pc_plus4 = head_entry.pc + XLEN'(PC_INC);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RUN:   if (i_redirect && inflight_q) state_d = S_FLUSH;
            S_FLUSH: state_d = i_redirect ? S_FLUSH : S_RUN;
            default: state_d = S_RUN;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pc_q       <= RESET_PC;
            req_pc_q   <= RESET_PC;
            inflight_q <= 1'b0;
            state_q    <= S_RUN;
        end else begin
            inflight_q <= o_imem_req;
            state_q    <= state_d;
            if (o_imem_req) begin
                req_pc_q <= pc_q;
            end
            if (i_redirect) begin
                pc_q <= {i_redirect_pc[XLEN-1:2], 2'b00};
            end else if (o_imem_req) begin
                pc_q <= pc_q + XLEN'(PC_INC);
            end
        end
    end

`ifdef IF_FETCH_QUEUE_PERF_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] flush_cnt_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            fetch_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (push) fetch_cnt_q <= fetch_cnt_q + 32'd1;
            if (i_redirect) flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign o_fetch_cnt = fetch_cnt_q;
    assign o_flush_cnt = flush_cnt_q;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            assert (!(push && full));
        end
    end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Scoreboard bench for if_fetch_queue: directed phases push expected heads, a monitor checks pops.
module tb_if_fetch_queue;

    logic        i_clk;
    logic        i_rst;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic [31:0] i_imem_rdata;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_inst;
    logic [31:0] o_pc;
    logic [31:0] o_pc_plus4;
`ifdef IF_FETCH_QUEUE_PERF_EN
    logic [31:0] o_fetch_cnt;
    logic [31:0] o_flush_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    if_fetch_queue #(
        .XLEN     (32),
        .ILEN     (32),
        .DEPTH    (4),
        .RESET_PC (32'h100)
    ) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc),
        .o_imem_req    (o_imem_req),
        .o_imem_addr   (o_imem_addr),
        .i_imem_rdata  (i_imem_rdata),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .o_inst        (o_inst),
        .o_pc          (o_pc),
`ifdef IF_FETCH_QUEUE_PERF_EN
        .o_fetch_cnt   (o_fetch_cnt),
        .o_flush_cnt   (o_flush_cnt),
`endif
        .o_pc_plus4    (o_pc_plus4)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return pc ^ 32'h5A5A_C3C3;
    endfunction

    // Synchronous instruction memory with one-cycle latency.
    always @(posedge i_clk) begin
        i_imem_rdata <= o_imem_req ? inst_of(o_imem_addr) : 32'hBAD0_BAD0;
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic load_exp(input logic [31:0] start, input int n);
        exp_q.delete();
        for (int k = 0; k < n; k++) exp_q.push_back(start + 32'(4 * k));
    endtask

    // Monitor: every accepted head is compared with the next expected PC.
    always @(negedge i_clk) begin
        if (!i_rst && o_valid && i_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL head_unexpected: got pc %h expected no output", o_pc);
            end else begin
                logic [31:0] epc;
                epc = exp_q.pop_front();
                check("head_pc", o_pc, epc);
                check("head_inst", o_inst, inst_of(epc));
                check("head_pc_plus4", o_pc_plus4, epc + 32'd4);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        i_rst         = 1'b1;
        i_ready       = 1'b0;
        i_redirect    = 1'b0;
        i_redirect_pc = 32'h0;
        load_exp(32'h100, 32);

        // Reset and stall fill
        for (int i = 0; i < 2; i++) begin
            tick();
            check("rst_addr", o_imem_addr, 32'h100);
            check("rst_valid", {31'b0, o_valid}, 32'd0);
            check("rst_req", {31'b0, o_imem_req}, 32'd0);
        end
        i_rst = 1'b0;
        #1;
        check("req0", {31'b0, o_imem_req}, 32'd1);
        check("addr0", o_imem_addr, 32'h100);
        tick();
        check("addr1", o_imem_addr, 32'h104);
        check("valid_lat1", {31'b0, o_valid}, 32'd0);
        tick();
        check("addr2", o_imem_addr, 32'h108);
        check("valid_lat2", {31'b0, o_valid}, 32'd1);
        tick();
        check("addr3", o_imem_addr, 32'h10C);
        check("req3", {31'b0, o_imem_req}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("stall_req", {31'b0, o_imem_req}, 32'd0);
            check("stall_pc", o_imem_addr, 32'h110);
        end
        check("stall_head", o_pc, 32'h100);

        // Release stall into a steady stream
        i_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            check("stream_valid", {31'b0, o_valid}, 32'd1);
            tick();
        end

        // Redirect with two queued and one in flight
        i_redirect    = 1'b1;
        i_redirect_pc = 32'h2003;
        #1;
        check("redir_req", {31'b0, o_imem_req}, 32'd0);
        tick();
        i_redirect = 1'b0;
        load_exp(32'h2000, 16);
        #1;
        check("redir_valid1", {31'b0, o_valid}, 32'd0);
        check("redir_req1", {31'b0, o_imem_req}, 32'd1);
        check("redir_addr", o_imem_addr, 32'h2000);
        tick();
        check("redir_valid2", {31'b0, o_valid}, 32'd0);
        tick();
        check("redir_valid3", {31'b0, o_valid}, 32'd1);
        check("redir_head", o_pc, 32'h2000);
        for (int i = 0; i < 6; i++) tick();

        // Redirect near the top of the address space to exercise wrap
        i_redirect    = 1'b1;
        i_redirect_pc = 32'hFFFF_FFF8;
        tick();
        i_redirect = 1'b0;
        load_exp(32'hFFFF_FFF8, 16);
        #1;
        check("wrap_addr0", o_imem_addr, 32'hFFFF_FFF8);
        tick();
        check("wrap_addr1", o_imem_addr, 32'hFFFF_FFFC);
        tick();
        check("wrap_addr2", o_imem_addr, 32'h0);
        check("wrap_head0", o_pc, 32'hFFFF_FFF8);
        tick();
        i_ready = 1'b0;
        check("wrap_head1", o_pc, 32'hFFFF_FFFC);
        check("wrap_plus4", o_pc_plus4, 32'h0);

        // Fill, then reset while full
        for (int i = 0; i < 8; i++) tick();
        check("full_req", {31'b0, o_imem_req}, 32'd0);
        check("full_valid", {31'b0, o_valid}, 32'd1);
        check("full_addr", o_imem_addr, 32'hC);
        i_rst = 1'b1;
        tick();
        load_exp(32'h100, 16);
        check("rst2_valid", {31'b0, o_valid}, 32'd0);
        check("rst2_addr", o_imem_addr, 32'h100);
        check("rst2_req", {31'b0, o_imem_req}, 32'd0);
        i_rst   = 1'b0;
        i_ready = 1'b1;
        #1;
        check("rst2_req0", {31'b0, o_imem_req}, 32'd1);
        tick();
        check("rst2_valid1", {31'b0, o_valid}, 32'd0);
        tick();
        check("rst2_valid2", {31'b0, o_valid}, 32'd1);
        check("rst2_head", o_pc, 32'h100);
        for (int i = 0; i < 4; i++) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
